// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder to APB3 requester bridge. One transfer in flight, every
// output registered, optional ACCESS-phase timeout reported as an AHB ERROR.
module ahb_apb_bridge #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  // AHB-Lite responder
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  // APB3 requester
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [2:0] {
    IDLE, DATA, SETUP, ACCESS, DONE, ERR1, ERR2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [7:0] TMO_LIM    = TMO_CYC[7:0];
  localparam bit         TMO_EN     = (TMO_CYC != 0);

  state_t     state;
  logic [2:0] size_q;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_cnt_inc;
  logic       accept;
  logic       unused_inputs;

  // Only NONSEQ/SEQ (htrans[1]=1) start a transfer; burst and protection
  // attributes have no meaning on APB.
  assign accept        = hsel && htrans[1];
  assign tmo_cnt_inc   = tmo_cnt + 8'd1;
  assign unused_inputs = ^{hburst, hprot, htrans[0]};

  // Outputs are assigned together with the next state so each one is a flop
  // whose value matches the state being entered.
  // NOTE: all state and output registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state   <= IDLE;
      size_q  <= 3'd0;
      tmo_cnt <= 8'd0;
      hready  <= 1'b1;
      hresp   <= RESP_OKAY;
      hrdata  <= 32'd0;
      paddr   <= 32'd0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR2: begin
          hresp <= RESP_OKAY;
          if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            size_q <= hsize;
            hready <= 1'b0;
            state  <= DATA;
          end else begin
            hready <= 1'b1;
            state  <= IDLE;
          end
        end

        DATA: begin
          if (pwrite) pwdata <= hwdata;
          // Transfers wider than 32 bits cannot be carried by APB.
          if (size_q > 3'd2) begin
            hresp <= RESP_ERROR;
            state <= ERR1;
          end else begin
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= 8'd0;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              hresp <= RESP_ERROR;
              state <= ERR1;
            end else begin
              if (!pwrite) hrdata <= prdata;
              hready <= 1'b1;
              state  <= DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt_inc;
            // Abort in the cycle where the counter reaches the limit, so
            // TMO_CYC counts the ACCESS cycles spent waiting.
            if (TMO_EN && tmo_cnt_inc == TMO_LIM) begin
              psel    <= 1'b0;
              penable <= 1'b0;
              hresp   <= RESP_ERROR;
              state   <= ERR1;
            end
          end
        end

        ERR1: begin
          hready <= 1'b1;
          hresp  <= RESP_ERROR;
          state  <= ERR2;
        end

        default: begin
          hready  <= 1'b1;
          hresp   <= RESP_OKAY;
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: reset, reads, writes with wait states,
// slave error, timeout, illegal size, back-to-back and mid-transfer reset.
module tb_ahb_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  ahb_apb_bridge #(.TMO_CYC(4)) dut (
    .pll_core_cpuclk(clk),
    .pad_cpu_rst    (rst),
    .hsel           (hsel),
    .haddr          (haddr),
    .htrans         (htrans),
    .hwrite         (hwrite),
    .hsize          (hsize),
    .hwdata         (hwdata),
    .hburst         (hburst),
    .hprot          (hprot),
    .hready         (hready),
    .hresp          (hresp),
    .hrdata         (hrdata),
    .paddr          (paddr),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ahb_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic ahb_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'hFFFF_FFFF;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  // Observed hready/hresp/psel/penable packed as {hready, hresp, psel, penable}.
  function automatic logic [31:0] ctl();
    return {27'd0, hready, hresp, psel, penable};
  endfunction

  initial begin
    rst = 1'b1; hburst = 3'd0; hprot = 4'd0; hwdata = 32'd0;
    prdata = 32'd0; pready = 1'b1; pslverr = 1'b0;
    ahb_idle();
    tick(); tick();
    check("rst_ctl",    ctl(),  32'b1_00_0_0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_paddr",  paddr,  32'd0);
    check("rst_pwrite", {31'd0, pwrite}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    rst = 1'b0;
    tick();

    // BUSY and unselected NONSEQ are ignored.
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h1111_0000;
    tick();
    check("busy_ctl", ctl(), 32'b1_00_0_0);
    hsel = 1'b0; htrans = 2'b10;
    tick();
    check("nosel_ctl",   ctl(), 32'b1_00_0_0);
    check("nosel_paddr", paddr, 32'd0);

    // Zero-wait read.
    pready = 1'b1; prdata = 32'hA5A5_1234;
    ahb_addr(32'h4000_0010, 1'b0, 3'd2);
    tick();                                   // A+1 DATA
    ahb_idle();
    check("rd_data_ctl", ctl(), 32'b0_00_0_0);
    tick();                                   // A+2 SETUP
    check("rd_setup_ctl", ctl(),  32'b0_00_1_0);
    check("rd_paddr",     paddr,  32'h4000_0010);
    check("rd_pwrite",    {31'd0, pwrite}, 32'd0);
    tick();                                   // A+3 ACCESS
    check("rd_access_ctl", ctl(), 32'b0_00_1_1);
    tick();                                   // A+4 DONE
    check("rd_done_ctl", ctl(),  32'b1_00_0_0);
    check("rd_hrdata",   hrdata, 32'hA5A5_1234);
    prdata = 32'h0BAD_0BAD;
    tick();
    check("rd_idle_ctl", ctl(),  32'b1_00_0_0);
    check("rd_hold",     hrdata, 32'hA5A5_1234);

    // Write with 3 wait states; hwdata valid only in the data phase.
    pready = 1'b0;
    ahb_addr(32'h4000_0020, 1'b1, 3'd2);
    hwdata = 32'h1234_5678;
    tick();                                   // A+1 DATA
    ahb_idle();
    hwdata = 32'hDEAD_BEEF;
    tick();                                   // A+2 SETUP
    hwdata = 32'h0;
    check("wr_setup_ctl", ctl(), 32'b0_00_1_0);
    check("wr_pwdata_s",  pwdata, 32'hDEAD_BEEF);
    check("wr_pwrite",    {31'd0, pwrite}, 32'd1);
    for (int i = 0; i < 4; i++) begin         // A+3..A+6 ACCESS
      tick();
      check($sformatf("wr_access%0d_ctl", i), ctl(), 32'b0_00_1_1);
      check($sformatf("wr_access%0d_pwdata", i), pwdata, 32'hDEAD_BEEF);
      check($sformatf("wr_access%0d_paddr", i), paddr, 32'h4000_0020);
      if (i == 3) pready = 1'b1;              // counter is 3 here: ready beats timeout
    end
    tick();                                   // A+7 DONE
    check("wr_done_ctl", ctl(),  32'b1_00_0_0);
    check("wr_hrdata",   hrdata, 32'hA5A5_1234);
    tick();

    // Slave error on first ACCESS cycle, then a new transfer accepted in ERR2.
    pready = 1'b1; pslverr = 1'b1;
    ahb_addr(32'h4000_0030, 1'b0, 3'd2);
    tick(); ahb_idle();                       // DATA
    tick();                                   // SETUP
    tick();                                   // ACCESS
    check("err_access_ctl", ctl(), 32'b0_00_1_1);
    tick();                                   // ERR1
    pslverr = 1'b0;
    check("err1_ctl", ctl(), 32'b0_01_0_0);
    tick();                                   // ERR2
    check("err2_ctl", ctl(), 32'b1_01_0_0);
    ahb_addr(32'h4000_0040, 1'b0, 3'd1);
    prdata = 32'h0000_C0DE;
    tick();                                   // DATA
    ahb_idle();
    check("err_next_ctl", ctl(), 32'b0_00_0_0);
    tick();
    check("err_next_paddr", paddr, 32'h4000_0040);
    tick(); tick();                           // ACCESS, DONE
    check("err_next_done", ctl(),  32'b1_00_0_0);
    check("err_next_rd",   hrdata, 32'h0000_C0DE);
    tick();

    // Timeout with TMO_CYC=4: four ACCESS cycles then a two-cycle ERROR.
    pready = 1'b0;
    ahb_addr(32'h4000_0050, 1'b0, 3'd2);
    tick(); ahb_idle();
    tick();                                   // SETUP
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tmo_access%0d_ctl", i), ctl(), 32'b0_00_1_1);
    end
    tick();
    check("tmo_err1_ctl", ctl(), 32'b0_01_0_0);
    tick();
    check("tmo_err2_ctl", ctl(), 32'b1_01_0_0);
    tick();
    check("tmo_idle_ctl", ctl(), 32'b1_00_0_0);
    pready = 1'b1;

    // hsize=3 never touches APB.
    ahb_addr(32'h4000_0060, 1'b1, 3'b011);
    tick(); ahb_idle();
    check("sz_data_ctl", ctl(), 32'b0_00_0_0);
    tick();
    check("sz_err1_ctl", ctl(), 32'b0_01_0_0);
    tick();
    check("sz_err2_ctl", ctl(), 32'b1_01_0_0);
    tick();

    // Back-to-back: new NONSEQ in DONE, then reset pulsed in ACCESS.
    prdata = 32'h7777_0001;
    ahb_addr(32'h4000_0070, 1'b0, 3'd2);
    tick(); ahb_idle();
    tick(); tick(); tick();                   // SETUP, ACCESS, DONE
    check("b2b_done1", ctl(),  32'b1_00_0_0);
    check("b2b_rd1",   hrdata, 32'h7777_0001);
    ahb_addr(32'h4000_0080, 1'b0, 3'd2);
    tick(); ahb_idle();                       // DATA
    check("b2b_data2", ctl(), 32'b0_00_0_0);
    tick();                                   // SETUP two cycles after DONE
    check("b2b_setup2", ctl(), 32'b0_00_1_0);
    check("b2b_paddr2", paddr, 32'h4000_0080);
    pready = 1'b0;
    tick();                                   // ACCESS
    check("b2b_access2", ctl(), 32'b0_00_1_1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pready = 1'b1;
    check("midrst_ctl",   ctl(),  32'b1_00_0_0);
    check("midrst_paddr", paddr,  32'd0);
    check("midrst_hrdata", hrdata, 32'd0);
    tick();
    check("midrst_idle", ctl(), 32'b1_00_0_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have parameter: TMO_CYC, default 255, ACCESS-phase timeout in cycles; 0 disables the timeout.
REQ-002 SHALL have ports:
- pll_core_cpuclk  in  1  sole clock, rising edge.
- pad_cpu_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have AHB-Lite responder ports:
- hsel  in  1  slave select.
- haddr  in  32  address.
- htrans  in  2  transfer type.
- hwrite  in  1  write.
- hsize  in  3  size.
- hwdata  in  32  write data, valid in data phase.
- hburst  in  3  ignored.
- hprot  in  4  ignored.
- hready  out  1  transfer done.
- hresp  out  2  response; OKAY=00, ERROR=01.
- hrdata  out  32  read data.
REQ-004 SHALL have APB3 requester ports:
- paddr  out  32  address.
- psel  out  1  select.
- penable  out  1  enable.
- pwrite  out  1  direction.
- pwdata  out  32  write data.
- prdata  in  32  read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.
REQ-005 SHALL register every output; no input SHALL reach an output combinationally.

Function
REQ-006 SHALL implement states IDLE, DATA, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-007 SHALL accept a transfer only in IDLE, DONE or ERR2, when hsel=1 and htrans[1]=1; NONSEQ and SEQ SHALL be treated identically.
REQ-008 SHALL ignore IDLE and BUSY htrans values: no state change, no APB activity.
REQ-009 On acceptance, SHALL latch haddr into paddr, hwrite into pwrite and hsize internally, then go to DATA.
REQ-010 In DATA, SHALL hold hready=0 and latch hwdata into pwdata when pwrite=1.
- If latched hsize>2, SHALL go to ERR1 without any APB access.
- Otherwise SHALL go to SETUP.
REQ-011 In SETUP, SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-012 In ACCESS, SHALL drive psel=1, penable=1 and hold paddr, pwrite, pwdata stable.
- On pready=1 with pslverr=0: SHALL latch prdata into hrdata (reads only), drop psel/penable, go to DONE.
- On pready=1 with pslverr=1: SHALL drop psel/penable and go to ERR1.
REQ-013 In DONE, SHALL drive hready=1, hresp=OKAY for one cycle; next state is DATA if a new transfer is accepted, else IDLE.
REQ-014 In ERR1, SHALL drive hready=0, hresp=ERROR.
REQ-015 In ERR2, SHALL drive hready=1, hresp=ERROR; next state is DATA if a new transfer is accepted, else IDLE.
REQ-016 hready SHALL be 0 in DATA, SETUP, ACCESS and ERR1, and 1 in IDLE, DONE and ERR2.
REQ-017 hresp SHALL be OKAY in every state except ERR1 and ERR2.
REQ-018 hrdata SHALL hold its last latched value outside DONE; write transfers SHALL NOT modify hrdata.
REQ-019 Timeout counter: 8 bits, cleared on ACCESS entry, incremented each ACCESS cycle with pready=0.
- When the counter equals TMO_CYC (TMO_CYC≠0), SHALL drop psel/penable and go to ERR1.
- pready=1 in that same cycle SHALL take priority over the timeout.
REQ-020 Read latency: address phase at cycle A, ACCESS at A+3, zero-wait pready gives hready=1 in DONE at A+4.

Reset
REQ-021 While pad_cpu_rst=1 at a clock edge, state SHALL become IDLE.
REQ-022 Reset values: hready=1, hresp=00, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, timeout counter=0.
REQ-023 Reset asserted mid-transfer in any state SHALL abort it: psel=0 on the next edge, no response completed.

Verification
REQ-024 Zero-wait read: haddr=0x40000010, pready=1, prdata=0xA5A5_1234 -> psel high for 2 cycles, hready=1 with hrdata=0xA5A5_1234 at A+4, hresp=00.
REQ-025 Write with 3 wait states: hwdata=0xDEAD_BEEF -> pwdata=0xDEAD_BEEF stable through SETUP+ACCESS, penable high 4 cycles, hready=1 at A+7.
REQ-026 pslverr=1 on first ACCESS cycle -> ERR1 with hready=0/hresp=01, then ERR2 with hready=1/hresp=01; a new NONSEQ presented in ERR2 is accepted.
REQ-027 TMO_CYC=4, pready stuck 0 -> psel drops after 4 ACCESS cycles, two-cycle ERROR response follows; hsize=3'b011 -> ERROR response with psel never asserted.
REQ-028 Back-to-back: NONSEQ accepted in DONE -> second APB SETUP begins 2 cycles later; pad_cpu_rst pulsed in ACCESS -> psel=0, hready=1 next cycle.
